irq_pending_ctrl: RTL

//  - Upstream stage of the 4-to-2 priority encoder (prio_enc1_4to2).
//  - Synchronises 4 asynchronous request lines and detects their rising edges.
//  - Holds the detected edges in a sticky pending register, which drives the encoder's d input.
//  - Presents the winning request index to a consumer over a valid/ready handshake.
//  - Clears the matching pending bit when the consumer accepts the index.

---
 rtl/irq_pending_ctrl_pkg.sv | 16 +
 rtl/irq_pending_ctrl_if.sv | 20 ++
 rtl/prio_enc1_4to2.sv | 24 ++
 rtl/irq_pending_ctrl.sv | 98 +++++++++
 4 files changed

// File: rtl/irq_pending_ctrl_pkg.sv
// Shared definitions for the interrupt pending controller: sizes, FSM states and helpers.
package irq_pending_ctrl_pkg;

  localparam int unsigned NReq = 4;
  localparam int unsigned IdW  = 2;

  typedef enum logic [0:0] {
    StIdle    = 1'b0,
    StPresent = 1'b1
  } irq_state_e;

  function automatic logic [NReq-1:0] id_onehot(input logic [IdW-1:0] id);
    return NReq'(1) << id;
  endfunction

endpackage

// File: rtl/irq_pending_ctrl_if.sv
// Valid/ready handshake carrying the winning request index to its consumer.
interface irq_pending_ctrl_if;

  logic                                    irq_valid;
  logic [irq_pending_ctrl_pkg::IdW-1:0]    irq_id;
  logic                                    irq_ready;

  modport master (
    output irq_valid,
    output irq_id,
    input  irq_ready
  );

  modport slave (
    input  irq_valid,
    input  irq_id,
    output irq_ready
  );

endinterface

// File: rtl/prio_enc1_4to2.sv
// 4-to-2 priority encoder: highest set bit of d_i wins, v_o flags any bit set.
module prio_enc1_4to2
  import irq_pending_ctrl_pkg::*;
(
  input  logic [NReq-1:0] d_i,
  output logic [IdW-1:0]  q_o,
  output logic            v_o
);

  always_comb begin
    q_o = '0;
    v_o = |d_i;
    if (d_i[3]) begin
      q_o = 2'd3;
    end else if (d_i[2]) begin
      q_o = 2'd2;
    end else if (d_i[1]) begin
      q_o = 2'd1;
    end else begin
      q_o = 2'd0;
    end
  end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Synchronises request lines, latches rising edges as sticky pending bits and presents the
// highest-priority one over a valid/ready handshake. IRQ_MASK_EN adds a per-line mask input.
module irq_pending_ctrl
  import irq_pending_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NReq-1:0]     req_i,
`ifdef IRQ_MASK_EN
  input  logic [NReq-1:0]     irq_mask_i,
`endif
  output logic [NReq-1:0]     pending_o,
  output logic                lost_o,
  irq_pending_ctrl_if.master  irq_if
);

  logic [NReq-1:0] s1_q, s2_q, s3_q;
  logic [NReq-1:0] pending_q, pending_d;
  logic            lost_q, lost_d;
  irq_state_e      state_q, state_d;
  logic [IdW-1:0]  id_q, id_d;

  logic [NReq-1:0] req_edge;
  logic [NReq-1:0] clear;
  logic [NReq-1:0] eligible;
  logic [IdW-1:0]  enc_q;
  logic            enc_v;
  logic            valid;
  logic            accept;

  assign valid    = (state_q == StPresent);
  assign accept   = valid & irq_if.irq_ready;
  assign req_edge = s2_q & ~s3_q;
  assign clear    = accept ? id_onehot(id_q) : '0;

`ifdef IRQ_MASK_EN
  assign eligible = pending_q & ~irq_mask_i;
`else
  assign eligible = pending_q;
`endif

  prio_enc1_4to2 u_enc (
    .d_i (eligible),
    .q_o (enc_q),
    .v_o (enc_v)
  );

  // Set is applied after clear so a fresh edge survives a same-cycle accept.
  always_comb begin
    pending_d = (pending_q & ~clear) | req_edge;
    lost_d    = |(req_edge & pending_q & ~clear);
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    unique case (state_q)
      StIdle: begin
        if (enc_v) begin
          state_d = StPresent;
          id_d    = enc_q;
        end
      end
      StPresent: begin
        if (accept) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      pending_q <= '0;
      lost_q    <= 1'b0;
      state_q   <= StIdle;
      id_q      <= '0;
    end else begin
      s1_q      <= req_i;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      pending_q <= pending_d;
      lost_q    <= lost_d;
      state_q   <= state_d;
      id_q      <= id_d;
    end
  end

  assign irq_if.irq_valid = valid;
  assign irq_if.irq_id    = id_q;
  assign pending_o        = pending_q;
  assign lost_o           = lost_q;

endmodule
